// File: rtl/blockings.sv
// Blocking-style chain (collapses to one flop, 1-cycle latency) beside a true DEPTH-stage shift register.
// Latency: o_q_block 1 edge, o_q_nonblock DEPTH edges; no flow control, both chains shift on every non-reset edge.
module blockings #(
  parameter int DEPTH = 3
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_d,
  output logic             o_q_block,
  output logic             o_q_nonblock,
  output logic [DEPTH-1:0] o_stages_nonblock
);

  // Every stage of the blocking chain copies its already-updated predecessor,
  // so all stages hold the same edge-sampled i_d; one flop carries that value.
  logic             blk_q;
  logic [DEPTH-1:0] nb_q;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      blk_q <= 1'b0;
      nb_q  <= '0;
    end else begin
      blk_q   <= i_d;
      nb_q[0] <= i_d;
      for (int k = 1; k < DEPTH; k++) begin
        nb_q[k] <= nb_q[k-1];
      end
    end
  end

  assign o_q_block         = blk_q;
  assign o_q_nonblock      = nb_q[DEPTH-1];
  assign o_stages_nonblock = nb_q;

endmodule

// File: tb/tb_blockings.sv
// Drives DEPTH=3/1/8 instances from shared inputs and checks them against an edge-sample history model.
module tb_blockings;

  logic       clk;
  logic       rstn;
  logic       d;

  logic       q_blk3, q_nb3;
  logic [2:0] st3;
  logic       q_blk1, q_nb1;
  logic [0:0] st1;
  logic       q_blk8, q_nb8;
  logic [7:0] st8;

  int n_checks = 0;
  int n_fail   = 0;

  // hist[k] is the i_d value sampled k+1 edges ago; a reset edge zeroes it all.
  logic [7:0] hist;

  blockings #(.DEPTH(3)) u_d3 (
    .i_clk(clk), .i_rstn(rstn), .i_d(d),
    .o_q_block(q_blk3), .o_q_nonblock(q_nb3), .o_stages_nonblock(st3)
  );
  blockings #(.DEPTH(1)) u_d1 (
    .i_clk(clk), .i_rstn(rstn), .i_d(d),
    .o_q_block(q_blk1), .o_q_nonblock(q_nb1), .o_stages_nonblock(st1)
  );
  blockings #(.DEPTH(8)) u_d8 (
    .i_clk(clk), .i_rstn(rstn), .i_d(d),
    .o_q_block(q_blk8), .o_q_nonblock(q_nb8), .o_stages_nonblock(st8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " blk3"},  {7'd0, q_blk3}, {7'd0, hist[0]});
    check({tag, " nb3"},   {7'd0, q_nb3},  {7'd0, hist[2]});
    check({tag, " st3"},   {5'd0, st3},    {5'd0, hist[2:0]});
    check({tag, " blk1"},  {7'd0, q_blk1}, {7'd0, hist[0]});
    check({tag, " nb1"},   {7'd0, q_nb1},  {7'd0, hist[0]});
    check({tag, " st1"},   {7'd0, st1},    {7'd0, hist[0]});
    check({tag, " blk8"},  {7'd0, q_blk8}, {7'd0, hist[0]});
    check({tag, " nb8"},   {7'd0, q_nb8},  {7'd0, hist[7]});
    check({tag, " st8"},   st8,            hist);
    check({tag, " d1eq"},  {7'd0, q_nb1},  {7'd0, q_blk1});
  endtask

  // Called 1 ns after an edge: optionally scribble on i_d mid-period, settle
  // the real values before the next edge, take the edge, then check.
  task automatic step(input logic dv, input logic rv, input bit junk, input string tag);
    if (junk) begin
      d = 1'($urandom);
      #($urandom_range(1, 3));
      d = ~d;
      #($urandom_range(1, 3));
    end
    d    = dv;
    rstn = rv;
    @(posedge clk);
    if (!rv) hist = '0;
    else     hist = {hist[6:0], dv};
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [5:0] pat;
    logic       ev;
    rstn = 1'b0;
    d    = 1'b1;
    hist = '0;

    // Reset held for two edges with i_d high
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst blk3", {7'd0, q_blk3}, 8'd0);
    check("rst nb3",  {7'd0, q_nb3},  8'd0);
    check("rst st3",  {5'd0, st3},    8'd0);
    check("rst st8",  st8,            8'd0);

    // Single pulse through DEPTH=3
    step(1'b1, 1'b1, 1'b0, "pulse0");
    check("pulse st3 e1", {5'd0, st3}, 8'b001);
    check("pulse blk3 e1", {7'd0, q_blk3}, 8'd1);
    step(1'b0, 1'b1, 1'b0, "pulse1");
    check("pulse st3 e2", {5'd0, st3}, 8'b010);
    check("pulse blk3 e2", {7'd0, q_blk3}, 8'd0);
    step(1'b0, 1'b1, 1'b0, "pulse2");
    check("pulse st3 e3", {5'd0, st3}, 8'b100);
    check("pulse nb3 e3", {7'd0, q_nb3}, 8'd1);
    step(1'b0, 1'b1, 1'b0, "pulse3");
    check("pulse st3 e4", {5'd0, st3}, 8'b000);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, "flush");

    // Pattern 1,1,0,1,0,0 then zeros so it drains through DEPTH=8
    pat = 6'b001011;
    for (int i = 0; i < 6; i++) step(pat[i], 1'b1, 1'b0, "pattern");
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0, "pattern drain");

    // Mid-period toggles on i_d must be invisible
    for (int i = 0; i < 12; i++) step(1'($urandom), 1'b1, 1'b1, "midperiod");

    // Build stages 101, then reset asserted between edges
    step(1'b1, 1'b1, 1'b0, "pre101");
    step(1'b0, 1'b1, 1'b0, "pre101");
    step(1'b1, 1'b1, 1'b0, "pre101");
    check("stages 101", {5'd0, st3}, 8'b101);
    #2 rstn = 1'b0;
    d = 1'b1;
    #2;
    check("async-free blk3", {7'd0, q_blk3}, {7'd0, hist[0]});
    check("async-free st3",  {5'd0, st3},    {5'd0, hist[2:0]});
    check("async-free st8",  st8,            hist);
    step(1'b1, 1'b0, 1'b0, "midrst");
    check("midrst st3", {5'd0, st3}, 8'd0);
    ev = 1'b1;
    step(ev, 1'b1, 1'b0, "release e1");
    step(1'b0, 1'b1, 1'b0, "release e2");
    check("release nb3 e2", {7'd0, q_nb3}, 8'd0);
    step(1'b0, 1'b1, 1'b0, "release e3");
    check("release nb3 e3", {7'd0, q_nb3}, {7'd0, ev});

    // Random stream with occasional reset
    for (int i = 0; i < 60; i++)
      step(1'($urandom), ($urandom_range(0, 9) != 0), 1'($urandom), "random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
